// File: rtl/hdlc_pkg.sv
// Shared HDLC constants and receive FSM state type.
package hdlc_pkg;

  localparam logic [7:0]  HDLC_FS      = 8'h7E;
  localparam logic [7:0]  HDLC_ADDRESS = 8'h00;
  localparam logic [7:0]  HDLC_CONTROL = 8'h03;
  localparam logic [15:0] CRC_RESIDUE  = 16'hF0B8;

  localparam int unsigned REPLY_LEN_WR = 8;
  localparam int unsigned REPLY_LEN_RD = 12;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    DATA
  } hdlc_state_e;

endpackage

// File: rtl/crc16_8.sv
// Byte-wide CRC-16/X.25 accumulator; crc_ok flags the good-frame residue.
module crc16_8
  import hdlc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       en,
  input  logic       crc_rst,
  output logic       crc_ok
);

  logic [15:0] crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || crc_rst) crc <= '1;
    else if (en)           crc <= crc_step(crc, d);
  end

  assign crc_ok = (crc == CRC_RESIDUE);

endmodule

// File: rtl/hdlc_rx_packet_parser.sv
// HDLC receive path: flag hunt, zero destuffing, byte assembly, CRC check and
// IPbus reply field extraction with one-cycle status strobes.
module hdlc_rx_packet_parser
  import hdlc_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_BYTES = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             frame_valid,
  output logic             crc_error,
  output logic             format_error,
  output logic [31:0]      reply_header,
  output logic [31:0]      reply_data,
  output logic             reply_has_data,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] crc_err_count
);

  localparam int unsigned IDX_W = $clog2(MAX_BYTES + 2);

  hdlc_state_e      state;
  logic [6:0]       raw_sr;
  logic [2:0]       ones;
  logic [2:0]       bit_cnt;
  logic [6:0]       byte_sr;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       frame_buf [MAX_BYTES];

  logic       crc_en, crc_rst, crc_ok;
  logic [7:0] crc_d;

  logic [7:0] raw_nxt, byte_nxt;
  logic       flag_det, abort, stuffed, kept, byte_done, prefix_miss;
  logic       len_ok, hdr_ok, len_rd;

  always_comb begin
    raw_nxt     = {bit_in, raw_sr};
    byte_nxt    = {bit_in, byte_sr};
    flag_det    = bit_valid && (raw_nxt == HDLC_FS);
    abort       = bit_valid && bit_in && (ones == 3'd6);
    stuffed     = !bit_in && (ones == 3'd5);
    kept        = bit_valid && !stuffed && !flag_det && !abort && (state != HUNT);
    byte_done   = kept && (bit_cnt == 3'd7);
    // In SYNC, kept bits that still match a flag prefix (0,1,1,1,1,1,1) may be
    // another flag; the first deviation marks the start of real frame data.
    prefix_miss = (bit_cnt == 3'd0) ? bit_in : !bit_in;
    len_rd      = (byte_idx == IDX_W'(REPLY_LEN_RD));
    len_ok      = len_rd || (byte_idx == IDX_W'(REPLY_LEN_WR));
    hdr_ok      = (frame_buf[0] == HDLC_ADDRESS) && (frame_buf[1] == HDLC_CONTROL);
  end

  always_ff @(posedge clk) begin
    if (byte_done && (byte_idx < IDX_W'(MAX_BYTES))) frame_buf[byte_idx] <= byte_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= HUNT;
      raw_sr         <= '0;
      ones           <= '0;
      bit_cnt        <= '0;
      byte_sr        <= '0;
      byte_idx       <= '0;
      crc_en         <= 1'b0;
      crc_rst        <= 1'b0;
      crc_d          <= '0;
      busy           <= 1'b0;
      frame_valid    <= 1'b0;
      crc_error      <= 1'b0;
      format_error   <= 1'b0;
      reply_header   <= '0;
      reply_data     <= '0;
      reply_has_data <= 1'b0;
      frame_count    <= '0;
      crc_err_count  <= '0;
    end else begin
      frame_valid  <= 1'b0;
      crc_error    <= 1'b0;
      format_error <= 1'b0;
      crc_en       <= 1'b0;
      crc_rst      <= 1'b0;

      if (bit_valid) begin
        raw_sr <= raw_nxt[7:1];
        if (!bit_in)             ones <= '0;
        else if (ones != 3'd7)   ones <= ones + 3'd1;
      end

      if (abort) begin
        if (state == DATA) format_error <= 1'b1;
        state <= HUNT;
        busy  <= 1'b0;
      end else if (flag_det) begin
        if (state == DATA) begin
          if (bit_cnt != 3'd7) begin
            format_error <= 1'b1;
          end else if (byte_idx != '0) begin
            if (!len_ok || !hdr_ok) begin
              format_error <= 1'b1;
            end else if (!crc_ok) begin
              crc_error <= 1'b1;
              if (crc_err_count != '1) crc_err_count <= crc_err_count + CNT_W'(1);
            end else begin
              frame_valid    <= 1'b1;
              reply_header   <= {frame_buf[5], frame_buf[4], frame_buf[3], frame_buf[2]};
              reply_has_data <= len_rd;
              if (len_rd) reply_data <= {frame_buf[9], frame_buf[8], frame_buf[7], frame_buf[6]};
              if (frame_count != '1) frame_count <= frame_count + CNT_W'(1);
            end
          end
        end
        state    <= SYNC;
        busy     <= 1'b0;
        bit_cnt  <= '0;
        byte_idx <= '0;
        crc_rst  <= 1'b1;
      end else if (kept) begin
        byte_sr <= byte_nxt[7:1];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          if (byte_idx != IDX_W'(MAX_BYTES + 1)) byte_idx <= byte_idx + IDX_W'(1);
          crc_en <= 1'b1;
          crc_d  <= byte_nxt;
        end
        if ((state == SYNC) && prefix_miss) begin
          state <= DATA;
          busy  <= 1'b1;
        end
      end
    end
  end

  crc16_8 u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (crc_d),
    .en      (crc_en),
    .crc_rst (crc_rst),
    .crc_ok  (crc_ok)
  );

endmodule

// File: tb/tb_hdlc_rx_packet_parser.sv
// Directed bench for hdlc_rx_packet_parser: builds stuffed, flagged frames with
// a bench-side FCS and checks strobes, fields and counters.
module tb_hdlc_rx_packet_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        busy, frame_valid, crc_error, format_error, reply_has_data;
  logic [31:0] reply_header, reply_data;
  logic [15:0] frame_count, crc_err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fv = 0, n_ce = 0, n_fe = 0;
  int tx_ones = 0;
  logic [7:0] frm [16];
  int frm_n = 0;

  always #5 clk = ~clk;

  hdlc_rx_packet_parser #(.CNT_W(16), .MAX_BYTES(12)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bit_in         (bit_in),
    .bit_valid      (bit_valid),
    .busy           (busy),
    .frame_valid    (frame_valid),
    .crc_error      (crc_error),
    .format_error   (format_error),
    .reply_header   (reply_header),
    .reply_data     (reply_data),
    .reply_has_data (reply_has_data),
    .frame_count    (frame_count),
    .crc_err_count  (crc_err_count)
  );

  // Count strobe cycles so pulse width and exclusivity are both checked.
  always @(negedge clk) begin
    if (frame_valid)  n_fv <= n_fv + 1;
    if (crc_error)    n_ce <= n_ce + 1;
    if (format_error) n_fe <= n_fe + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    @(negedge clk);
    n_fv = 0; n_ce = 0; n_fe = 0;
  endtask

  task automatic send_raw(input logic b);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_sbit(input logic b);
    send_raw(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_raw(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_sbit(v[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_raw(f[i]);
    tx_ones = 0;
  endtask

  function automatic logic [15:0] fcs(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ frm[k][i];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'h8408;
      end
    return ~c;
  endfunction

  // Body with FCS; flip_idx >= 0 corrupts bit 0 of that byte after the FCS is fixed.
  task automatic send_body(input int flip_idx);
    logic [15:0] f;
    f = fcs(frm_n);
    for (int k = 0; k < frm_n; k++) send_byte((k == flip_idx) ? (frm[k] ^ 8'h01) : frm[k]);
    send_byte(f[7:0]);
    send_byte(f[15:8]);
  endtask

  task automatic load_hdr(input logic [7:0] ctrl, input logic [7:0] h0);
    frm[0] = 8'h00; frm[1] = ctrl; frm[2] = h0;
    frm[3] = 8'h06; frm[4] = 8'h01; frm[5] = 8'h20;
    frm_n = 6;
  endtask

  task automatic load_data(input logic [31:0] d);
    frm[6] = d[7:0]; frm[7] = d[15:8]; frm[8] = d[23:16]; frm[9] = d[31:24];
    frm_n = 10;
  endtask

  task automatic check_pulses(input string tag, input int fv, input int ce, input int fe);
    check({tag, ".frame_valid"},  n_fv, fv);
    check({tag, ".crc_error"},    n_ce, ce);
    check({tag, ".format_error"}, n_fe, fe);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy",          busy,           0);
    check("reset.frame_valid",   frame_valid,    0);
    check("reset.reply_header",  reply_header,   0);
    check("reset.reply_data",    reply_data,     0);
    check("reset.has_data",      reply_has_data, 0);
    check("reset.frame_count",   frame_count,    0);
    check("reset.crc_err_count", crc_err_count,  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write reply
    clr_counts();
    load_hdr(8'h03, 8'h1F);
    send_flag();
    send_body(-1);
    check("wr.busy_mid", busy, 1);
    send_flag();
    check("wr.busy_after", busy, 0);
    check_pulses("wr", 1, 0, 0);
    check("wr.reply_header", reply_header,   32'h2001061F);
    check("wr.has_data",     reply_has_data, 0);
    check("wr.frame_count",  frame_count,    1);

    // Read reply, closing flag of the previous frame is reused as opener
    clr_counts();
    load_hdr(8'h03, 8'h0F);
    load_data(32'hDEADBEEF);
    send_body(-1);
    send_flag();
    check_pulses("rd", 1, 0, 0);
    check("rd.reply_header", reply_header,   32'h2001060F);
    check("rd.reply_data",   reply_data,     32'hDEADBEEF);
    check("rd.has_data",     reply_has_data, 1);
    check("rd.frame_count",  frame_count,    2);

    // Payload rich in ones needing stuffing
    clr_counts();
    load_hdr(8'h03, 8'h0F);
    frm[6] = 8'hFF; frm[7] = 8'h7E; frm[8] = 8'h3F; frm[9] = 8'h00; frm_n = 10;
    send_body(-1);
    send_flag();
    check_pulses("stuff", 1, 0, 0);
    check("stuff.reply_data",  reply_data,  32'h003F7EFF);
    check("stuff.frame_count", frame_count, 3);

    // Corrupted payload bit
    clr_counts();
    load_hdr(8'h03, 8'h0F);
    load_data(32'h44332211);
    send_body(6);
    send_flag();
    check_pulses("crc", 0, 1, 0);
    check("crc.crc_err_count", crc_err_count, 1);
    check("crc.reply_data",    reply_data,    32'h003F7EFF);
    check("crc.frame_count",   frame_count,   3);

    // Eight bytes plus three stray bits before the flag
    clr_counts();
    load_hdr(8'h03, 8'h1F);
    send_body(-1);
    send_sbit(1'b1); send_sbit(1'b0); send_sbit(1'b1);
    send_flag();
    check_pulses("misalign", 0, 0, 1);

    // Bad control byte with otherwise valid FCS
    clr_counts();
    load_hdr(8'h13, 8'h1F);
    send_body(-1);
    send_flag();
    check_pulses("ctrl", 0, 0, 1);
    check("ctrl.reply_header", reply_header, 32'h2001060F);

    // Abort mid-frame, then a frame without an opening flag must be ignored
    clr_counts();
    load_hdr(8'h03, 8'h1F);
    for (int k = 0; k < 3; k++) send_byte(frm[k]);
    for (int i = 0; i < 7; i++) send_raw(1'b1);
    tx_ones = 0;
    check_pulses("abort", 0, 0, 1);
    check("abort.busy", busy, 0);
    clr_counts();
    send_body(-1);
    send_flag();
    check_pulses("hunt", 0, 0, 0);
    send_body(-1);
    send_flag();
    check_pulses("resync", 1, 0, 0);
    check("resync.frame_count", frame_count, 4);

    // Repeated flags then one frame
    clr_counts();
    load_hdr(8'h03, 8'h0F);
    load_data(32'hCAFEF00D);
    send_flag(); send_flag(); send_flag();
    send_body(-1);
    send_flag();
    check_pulses("flags", 1, 0, 0);
    check("flags.reply_data", reply_data, 32'hCAFEF00D);

    // Reset in the middle of a frame
    clr_counts();
    load_hdr(8'h03, 8'h1F);
    send_flag();
    for (int k = 0; k < 3; k++) send_byte(frm[k]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst.crc_err_count", crc_err_count, 0);
    check("rst.reply_data",    reply_data,    0);
    send_body(-1);
    send_flag();
    check_pulses("rst", 0, 0, 0);
    clr_counts();
    send_flag();
    send_body(-1);
    send_flag();
    check_pulses("post_rst", 1, 0, 0);
    check("post_rst.frame_count",  frame_count,  1);
    check("post_rst.reply_header", reply_header, 32'h2001061F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
